matrix_mem: RTL and testbench

Responder end of the matrix-engine memory interface: an 8-entry × 256-bit store holding 4×4 matrices of 16-bit elements. It answers read and write requests issued by the ALU and the execution engine over an en/rw/address handshake. Read data is registered and returned with a one-cycle `ack` pulse; writes commit on the sampling edge. After reset or `clr`, the block walks all entries through an initialisation sequence before it accepts requests.

---
 rtl/matrix_mem.sv | 80 ++++++++
 tb/tb_matrix_mem.sv | 134 +++++++++++++
 2 files changed

// File: rtl/matrix_mem.sv
// matrix_mem: 8 x 256-bit matrix store answering en/rw requests, self-initialising after rst or clr.
// MATRIX_MEM_PRELOAD_EN: INIT loads entry n with (n+1) * identity instead of zero.
module matrix_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             rw,
  input  logic [2:0]       address,
  input  logic [WIDTH-1:0] datain,
  input  logic             clr,
  output logic [WIDTH-1:0] dataout,
  output logic             ack,
  output logic             ready
);
  typedef enum logic {INIT, IDLE} state_t;
  state_t state_q, state_d;
  logic [2:0] init_ptr_q, init_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dataout_q, dataout_d, wdata;
  logic ack_q, ack_d, we;
  logic [2:0] waddr;
  function automatic logic [WIDTH-1:0] init_val(input logic [2:0] n);
    logic [WIDTH-1:0] v;
    logic [15:0] diag;
`ifdef MATRIX_MEM_PRELOAD_EN
    diag = 16'(n) + 16'd1;
`else
    diag = 16'(n) & 16'd0;
`endif
    v = '0;
    for (int i = 0; i < 4; i++) v[80*i +: 16] = diag;
    return v;
  endfunction
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    dataout_d  = dataout_q;
    ack_d      = 1'b0;
    we         = 1'b0;
    waddr      = address;
    wdata      = datain;
    if (clr) begin
      state_d    = INIT;
      init_ptr_d = '0;
    end else if (state_q == INIT) begin
      we         = 1'b1;
      waddr      = init_ptr_q;
      wdata      = init_val(init_ptr_q);
      init_ptr_d = init_ptr_q + 3'd1;
      state_d    = (init_ptr_q == 3'd7) ? IDLE : INIT;
    end else if (en) begin
      ack_d     = 1'b1;
      we        = !rw;
      dataout_d = rw ? mem_q[address] : dataout_q;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      dataout_q  <= '0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      dataout_q  <= dataout_d;
      ack_q      <= ack_d;
    end
  end
  // storage is left unreset; INIT rewrites every entry before ready rises
  always_ff @(posedge clk) begin
    if (we && !rst) mem_q[waddr] <= wdata;
  end
  assign dataout = dataout_q;
  assign ack     = ack_q;
  assign ready   = (state_q == IDLE);
endmodule

// File: tb/tb_matrix_mem.sv
// tb_matrix_mem: randomized scoreboard bench for matrix_mem against a whole-matrix reference model.
module tb_matrix_mem;
  logic clk = 1'b0;
  logic rst, en, rw, clr, ack, ready;
  logic [2:0] address;
  logic [255:0] datain, dataout;
  logic [255:0] ref_mem [8];
  logic [255:0] last_m, pat, pat2;
  logic [255:0] exp_q [$];
  logic rdy_m;
  int icnt;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  matrix_mem dut (
    .clk(clk), .rst(rst), .en(en), .rw(rw), .address(address), .datain(datain),
    .clr(clr), .dataout(dataout), .ack(ack), .ready(ready)
  );

  function automatic logic [255:0] init_val(input int n);
    logic [255:0] v;
    logic [15:0] diag;
    diag = 16'(n + 1);
`ifndef MATRIX_MEM_PRELOAD_EN
    diag = '0;
`endif
    v = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        v[16*(4*r+c) +: 16] = (r == c) ? diag : 16'd0;
    return v;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_reset();
    rdy_m = 1'b0;
    icnt = 0;
    last_m = '0;
    exp_q.delete();
  endtask

  // Apply one cycle of stimulus, advance the model, then check after the edge.
  task automatic step(input logic e, input logic r, input logic [2:0] a, input logic [255:0] d, input logic c);
    logic acc;
    acc = 1'b0;
    en = e; rw = r; address = a; datain = d; clr = c;
    if (c) begin
      rdy_m = 1'b0;
      icnt = 0;
    end else if (!rdy_m) begin
      icnt++;
      if (icnt == 8) begin
        rdy_m = 1'b1;
        for (int i = 0; i < 8; i++) ref_mem[i] = init_val(i);
      end
    end else if (e) begin
      acc = 1'b1;
      if (r) last_m = ref_mem[a];
      else ref_mem[a] = d;
      exp_q.push_back(last_m);
    end
    @(posedge clk);
    #1;
    chk("ready", 256'(ready), 256'(rdy_m));
    chk("ack", 256'(ack), 256'(acc));
    chk("dataout_hold", dataout, last_m);
  endtask

  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL sb_unexpected_ack: got ack=1 expected no pending request");
      end else chk("sb_data", dataout, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; rw = 1'b0; clr = 1'b0; address = '0; datain = '0;
    model_reset();
    #1;
    chk("reset_ready", 256'(ready), 256'd0);
    chk("reset_ack", 256'(ack), 256'd0);
    chk("reset_dataout", dataout, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) step(1'b0, 1'b0, 3'd0, '0, 1'b0);
    for (int k = 0; k < 16; k++) pat[16*k +: 16] = 16'(16 - k);
    step(1'b1, 1'b0, 3'd3, pat, 1'b0);
    step(1'b1, 1'b1, 3'd3, '0, 1'b0);
    chk("wr_rd_addr3", dataout, pat);
    step(1'b1, 1'b1, 3'd5, '0, 1'b0);
    chk("untouched_addr5", dataout, init_val(5));
    step(1'b0, 1'b0, 3'd0, '0, 1'b0);
    pat2 = rnd256();
    step(1'b1, 1'b0, 3'd1, pat2, 1'b1);
    repeat (9) step(1'b1, 1'b0, 3'd2, pat2, 1'b0);
    step(1'b1, 1'b1, 3'd2, '0, 1'b0);
    chk("held_write_addr2", dataout, pat2);
    step(1'b1, 1'b1, 3'd1, '0, 1'b0);
    chk("clr_addr1_init", dataout, init_val(1));
    step(1'b0, 1'b0, 3'd0, '0, 1'b1);
    repeat (4) step(1'b0, 1'b0, 3'd0, '0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", 256'(ready), 256'd0);
    chk("async_rst_ack", 256'(ack), 256'd0);
    chk("async_rst_dataout", dataout, '0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) step(1'b0, 1'b0, 3'd0, '0, 1'b0);
    repeat (300)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom), rnd256(),
           1'($urandom_range(0, 39) == 0));
    repeat (2) step(1'b0, 1'b0, 3'd0, '0, 1'b0);
    chk("sb_drain", 256'(exp_q.size()), 256'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
